// File: rtl/ps2_rx_fifo_apb.sv
// Purpose: PS/2 device-to-host receiver feeding a byte FIFO, read and controlled over APB.
// Latency: byte enters the FIFO on the cycle its synchronised stop-bit falling edge is seen; irq is registered.
// Backpressure: none towards PS/2; a byte arriving at a full FIFO is dropped and OVF is flagged.
// Ports: clock/reset_n (async active-low); in_p* APB slave (zero wait states, in_pprot/in_pstrb ignored);
//        ps2_clk/ps2_data asynchronous PS/2 line inputs; irq level interrupt.
module ps2_rx_fifo_apb #(
    parameter int FIFO_DEPTH = 16,
    parameter int TIMEOUT    = 4096
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] in_paddr,
    input  logic        in_psel,
    input  logic        in_penable,
    input  logic [2:0]  in_pprot,
    input  logic        in_pwrite,
    input  logic [31:0] in_pwdata,
    input  logic [3:0]  in_pstrb,
    output logic        in_pready,
    output logic [31:0] in_prdata,
    output logic        in_pslverr,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic        irq
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

    // Line synchronisers; clk_prev holds the previous synchronised clock for edge detection.
    logic clk_s1, clk_s2, clk_prev, dat_s1, dat_s2;
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
        end
    end
    logic fall;
    assign fall = clk_prev & ~clk_s2;

    // Registers
    rx_state_t        state, state_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             par, par_n;
    logic [TW-1:0]    tmo_cnt;
    logic [AW-1:0]    wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [CW-1:0]    count, count_n;
    logic             ovf, perr, ferr, en, irq_en;
    logic             ovf_n, perr_n, ferr_n, en_n, irq_en_n, irq_n;
    logic [7:0]       mem [FIFO_DEPTH];

    // APB decode
    logic access, rd_acc, wr_acc, sel_data, sel_status, sel_ctrl;
    assign access     = in_psel & in_penable;
    assign rd_acc     = access & ~in_pwrite;
    assign wr_acc     = access & in_pwrite;
    assign sel_data   = (in_paddr[3:0] == 4'h0);
    assign sel_status = (in_paddr[3:0] == 4'h4);
    assign sel_ctrl   = (in_paddr[3:0] == 4'h8);

    logic empty, full, flush, do_pop, do_push;
    logic push, perr_set, ferr_set, ovf_set;
    logic [2:0] w1c;
    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign flush   = wr_acc & sel_ctrl & in_pwdata[2];
    assign do_pop  = rd_acc & sel_data & ~empty & ~flush;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign do_push = push & (~full | do_pop) & ~flush;
    assign ovf_set = push & full & ~do_pop & ~flush;
    assign w1c     = (wr_acc & sel_status) ? in_pwdata[4:2] : 3'b000;

    // Receiver next state
    always_comb begin
        state_n   = state;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        par_n     = par;
        push      = 1'b0;
        perr_set  = 1'b0;
        ferr_set  = 1'b0;
        if (!en) begin
            state_n = IDLE;
        end else if (fall) begin
            case (state)
                IDLE: begin
                    if (!dat_s2) begin
                        state_n   = DATA;
                        bit_idx_n = 3'd0;
                    end
                end
                DATA: begin
                    shreg_n   = {dat_s2, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) state_n = PARITY;
                end
                PARITY: begin
                    par_n   = dat_s2;
                    state_n = STOP;
                end
                STOP: begin
                    state_n  = IDLE;
                    push     = dat_s2 & (^{shreg, par});
                    ferr_set = ~dat_s2;
                    perr_set = ~(^{shreg, par});
                end
                default: state_n = IDLE;
            endcase
        end else if (state != IDLE && tmo_cnt == TW'(TIMEOUT - 1)) begin
            state_n  = IDLE;
            ferr_set = 1'b1;
        end
    end

    // FIFO, flag and control next state
    always_comb begin
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        count_n  = count;
        if (flush) begin
            wr_ptr_n = '0;
            rd_ptr_n = '0;
            count_n  = '0;
        end else begin
            if (do_push) wr_ptr_n = wr_ptr + 1'b1;
            if (do_pop)  rd_ptr_n = rd_ptr + 1'b1;
            if (do_push && !do_pop)      count_n = count + 1'b1;
            else if (!do_push && do_pop) count_n = count - 1'b1;
        end
        // Set wins over a same-cycle clear.
        ovf_n    = ovf_set  | (ovf  & ~w1c[0]);
        perr_n   = perr_set | (perr & ~w1c[1]);
        ferr_n   = ferr_set | (ferr & ~w1c[2]);
        en_n     = (wr_acc & sel_ctrl) ? in_pwdata[0] : en;
        irq_en_n = (wr_acc & sel_ctrl) ? in_pwdata[1] : irq_en;
        irq_n    = irq_en_n & ((count_n != '0) | ovf_n | perr_n | ferr_n);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            bit_idx <= '0;
            shreg   <= '0;
            par     <= 1'b0;
            tmo_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            perr    <= 1'b0;
            ferr    <= 1'b0;
            en      <= 1'b1;
            irq_en  <= 1'b0;
            irq     <= 1'b0;
        end else begin
            state   <= state_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            par     <= par_n;
            if (!en || state == IDLE || fall) tmo_cnt <= '0;
            else                              tmo_cnt <= tmo_cnt + 1'b1;
            wr_ptr  <= wr_ptr_n;
            rd_ptr  <= rd_ptr_n;
            count   <= count_n;
            ovf     <= ovf_n;
            perr    <= perr_n;
            ferr    <= ferr_n;
            en      <= en_n;
            irq_en  <= irq_en_n;
            irq     <= irq_n;
        end
    end

    // Storage needs no reset: only entries below count are ever read.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= shreg;
    end

    // APB response
    assign in_pready  = access;
    assign in_pslverr = access & ~(sel_data | sel_status | sel_ctrl);
    always_comb begin
        in_prdata = 32'h0;
        if (rd_acc) begin
            if (sel_data && !empty) in_prdata = {23'b0, 1'b1, mem[rd_ptr]};
            else if (sel_status)    in_prdata = {16'b0, 8'(count), 3'b0, ferr, perr, ovf, full, empty};
            else if (sel_ctrl)      in_prdata = {30'b0, irq_en, en};
        end
    end

    logic unused_bits;
    assign unused_bits = ^{in_pprot, in_pstrb, in_paddr[31:4], in_pwdata[31:5]};
endmodule

// File: tb/tb_ps2_rx_fifo_apb.sv
module tb_ps2_rx_fifo_apb;
    localparam int DEPTH = 4;
    localparam int TMO   = 64;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] paddr;
    logic        psel, penable, pwrite;
    logic [31:0] pwdata;
    logic        pready, pslverr, irq;
    logic [31:0] prdata;
    logic        ps2_clk, ps2_data;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ps2_rx_fifo_apb #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_paddr   (paddr),
        .in_psel    (psel),
        .in_penable (penable),
        .in_pprot   (3'b000),
        .in_pwrite  (pwrite),
        .in_pwdata  (pwdata),
        .in_pstrb   (4'hF),
        .in_pready  (pready),
        .in_prdata  (prdata),
        .in_pslverr (pslverr),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .irq        (irq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d, output logic e);
        @(negedge clock);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
        @(negedge clock);
        penable = 1'b1;
        #1;
        d = prdata;
        e = pslverr;
        chk("pready_access", {31'b0, pready}, 32'h1);
        @(negedge clock);
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        e;
        apb_read(a, d, e);
        chk(tag, d, exp);
        chk({tag, "_slverr"}, {31'b0, e}, 32'h0);
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clock);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
        @(negedge clock);
        penable = 1'b1;
        @(negedge clock);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clock);
        ps2_data = b;
        repeat (3) @(negedge clock);
        ps2_clk = 1'b0;
        repeat (4) @(negedge clock);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[i]);
        ps2_bit((~^d) ^ par_flip);
        ps2_bit(stop);
        repeat (6) @(negedge clock);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;
        reset_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 32'h0; pwdata = 32'h0; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        chk("rst_pready",  {31'b0, pready},  32'h0);
        chk("rst_prdata",  prdata,           32'h0);
        chk("rst_pslverr", {31'b0, pslverr}, 32'h0);
        chk("rst_irq",     {31'b0, irq},     32'h0);
        reset_n = 1'b1;
        rd_chk("rst_status", 32'h4, 32'h1);
        rd_chk("rst_ctrl",   32'h8, 32'h1);

        // Good frame 0x1C then pop.
        send_frame(8'h1C, 1'b0, 1'b1);
        rd_chk("frame_1c_data", 32'h0, 32'h11C);
        rd_chk("frame_1c_status", 32'h4, 32'h1);

        // Bad parity, then W1C of PERR.
        send_frame(8'h1C, 1'b1, 1'b1);
        rd_chk("perr_status", 32'h4, 32'h9);
        apb_write(32'h4, 32'h8);
        rd_chk("perr_cleared", 32'h4, 32'h1);

        // Overflow with five frames into a four-entry FIFO.
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b1);
        rd_chk("ovf_status", 32'h4, 32'h0406);
        for (int i = 1; i <= 4; i++) rd_chk("ovf_drain", 32'h0, 32'h100 + i);
        rd_chk("empty_data", 32'h0, 32'h0);
        apb_write(32'h4, 32'h4);
        rd_chk("ovf_cleared", 32'h4, 32'h1);

        // Unmapped offset.
        apb_read(32'hC, d, e);
        chk("unmapped_slverr", {31'b0, e}, 32'h1);
        chk("unmapped_prdata", d, 32'h0);

        // Timeout mid-frame, then a clean frame.
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
        repeat (TMO + 20) @(negedge clock);
        rd_chk("timeout_status", 32'h4, 32'h11);
        send_frame(8'h5A, 1'b0, 1'b1);
        rd_chk("after_timeout_data", 32'h0, 32'h15A);
        apb_write(32'h4, 32'h10);
        rd_chk("ferr_cleared", 32'h4, 32'h1);

        // Bad stop bit.
        send_frame(8'h3C, 1'b0, 1'b0);
        rd_chk("bad_stop_status", 32'h4, 32'h11);
        apb_write(32'h4, 32'h1C);

        // Receiver disabled: nothing captured, no flags.
        apb_write(32'h8, 32'h0);
        send_frame(8'h42, 1'b0, 1'b1);
        rd_chk("disabled_status", 32'h4, 32'h1);

        // Interrupt follows a received byte and drops after the pop.
        apb_write(32'h8, 32'h3);
        #1;
        chk("irq_idle", {31'b0, irq}, 32'h0);
        send_frame(8'h33, 1'b0, 1'b1);
        #1;
        chk("irq_set", {31'b0, irq}, 32'h1);
        rd_chk("irq_data", 32'h0, 32'h133);
        #1;
        chk("irq_after_pop", {31'b0, irq}, 32'h0);
        apb_write(32'h8, 32'h1);

        // Pop from a full FIFO on the cycle the next byte is pushed.
        for (int i = 0; i < 4; i++) send_frame(8'hA1 + 8'(i), 1'b0, 1'b1);
        rd_chk("full_status", 32'h4, 32'h0402);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(d[0] ^ d[0] ^ ((8'hA5 >> i) & 8'h1) != 0);
        ps2_bit(~^8'hA5);
        @(negedge clock);
        ps2_data = 1'b1;
        repeat (3) @(negedge clock);
        ps2_clk = 1'b0;
        @(negedge clock);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0;
        @(negedge clock);
        penable = 1'b1;
        #1;
        chk("simul_pop_data", prdata, 32'h1A1);
        @(negedge clock);
        psel = 1'b0; penable = 1'b0;
        repeat (2) @(negedge clock);
        ps2_clk = 1'b1;
        repeat (4) @(negedge clock);
        rd_chk("simul_status", 32'h4, 32'h0402);
        rd_chk("simul_next", 32'h0, 32'h1A2);

        // Flush empties the FIFO; the flush bit reads back 0.
        apb_write(32'h8, 32'h5);
        rd_chk("flush_status", 32'h4, 32'h1);
        rd_chk("flush_ctrl", 32'h8, 32'h1);

        // Reset in the middle of a frame.
        apb_write(32'h8, 32'h3);
        ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
        @(negedge clock);
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        chk("midrst_irq", {31'b0, irq}, 32'h0);
        reset_n = 1'b1;
        rd_chk("midrst_ctrl", 32'h8, 32'h1);
        send_frame(8'h77, 1'b0, 1'b1);
        rd_chk("midrst_data", 32'h0, 32'h177);
        rd_chk("midrst_status", 32'h4, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
